// File: rtl/minterm_pkg.sv
// Shared definitions for the minterm sweeper: FSM encoding and sweep constants.
package minterm_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Signature start value after reset or an accepted start.
    localparam logic [15:0] SIG_INIT   = 16'hFFFF;
    // Final minterm of a 7-input function; the index never wraps past it.
    localparam logic [6:0]  LAST_INDEX = 7'd127;

    // True in the states where a sweep is in flight.
    function automatic logic is_busy(input state_t s);
        return (s == S_DRIVE) || (s == S_SETTLE) || (s == S_SAMPLE);
    endfunction

endpackage

// File: rtl/sig_crc16.sv
// Serial CRC-16 signature register: MSB-first shift with feedback polynomial POLY.
module sig_crc16
    import minterm_pkg::*;
#(
    parameter logic [15:0] POLY = 16'h1021
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] sig
);

    logic [15:0] r_sig;

    // Signature register: reload on clear, fold one bit in per enabled cycle.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= SIG_INIT;
        end else if (clear) begin
            r_sig <= SIG_INIT;
        end else if (en) begin
            r_sig <= {r_sig[14:0], 1'b0} ^ ((r_sig[15] ^ bit_in) ? POLY : 16'h0000);
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/minterm_sweeper.sv
// Walks all 128 minterms of a 7-input function, samples its output after a
// configurable settle delay, and reports the ones count and a CRC signature.
module minterm_sweeper
    import minterm_pkg::*;
#(
    parameter int          SETTLE   = 1,
    parameter logic [15:0] SIG_POLY = 16'h1021
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        busy,
    output logic        done,
    output logic [7:0]  ones_count,
    output logic [15:0] signature
);

    // Last value of the wait counter before leaving SETTLE (unused when SETTLE=0).
    localparam logic [3:0] WAIT_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_index;
    logic [3:0]  r_wait;
    logic [7:0]  r_ones;
    logic        w_accept;
    logic        w_sample;
    logic        w_busy;

    assign w_busy   = is_busy(r_state);
    assign w_accept = (r_state == S_IDLE) && start;
    // A paused SAMPLE neither accumulates nor advances.
    assign w_sample = (r_state == S_SAMPLE) && !pause;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; pause freezes every in-flight state.
    // NOTE: w_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (!pause) begin
                    w_next = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
                end
            end
            S_SETTLE: begin
                if (!pause && (r_wait == WAIT_LAST)) begin
                    w_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (!pause) begin
                    w_next = (r_index == LAST_INDEX) ? S_DONE : S_DRIVE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Minterm index: cleared on accept, stepped after each sample, stops at 127.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index <= 7'd0;
        end else if (w_accept) begin
            r_index <= 7'd0;
        end else if (w_sample && (r_index != LAST_INDEX)) begin
            r_index <= r_index + 7'd1;
        end
    end

    // Settle wait counter: zeroed on leaving DRIVE, counts up through SETTLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= 4'd0;
        end else if (w_accept) begin
            r_wait <= 4'd0;
        end else if ((r_state == S_DRIVE) && !pause) begin
            r_wait <= 4'd0;
        end else if ((r_state == S_SETTLE) && !pause && (r_wait != WAIT_LAST)) begin
            r_wait <= r_wait + 4'd1;
        end
    end

    // Ones counter: 8 bits so a full sweep of ones (128) fits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones <= 8'd0;
        end else if (w_accept) begin
            r_ones <= 8'd0;
        end else if (w_sample) begin
            r_ones <= r_ones + {7'd0, f_in};
        end
    end

    sig_crc16 #(
        .POLY   (SIG_POLY)
    ) u_sig (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_accept),
        .en     (w_sample),
        .bit_in (f_in),
        .sig    (signature)
    );

    // Function inputs follow the index only while a sweep is in flight.
    assign {a, b, c, d, e, f, g} = w_busy ? r_index : 7'd0;
    assign busy       = w_busy;
    assign done       = (r_state == S_DONE);
    assign ones_count = r_ones;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Scoreboard bench for minterm_sweeper: random and fixed truth tables drive
// f_in, a behavioural model predicts ones count, signature and latency.
module tb_minterm_sweeper;

    localparam int S1 = 1;
    localparam int S0 = 0;

    typedef struct {
        int          ones;
        logic [15:0] sig;
        int          t_start;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, pause, f_in;
    logic        a, b, c, d, e, f, g, busy, done;
    logic [7:0]  ones_count;
    logic [15:0] signature;
    logic [6:0]  idx;

    logic        start_z, f_in_z;
    logic        a_z, b_z, c_z, d_z, e_z, f_z, g_z, busy_z, done_z;
    logic [7:0]  ones_z;
    logic [15:0] sig_z;
    logic [6:0]  idx_z;

    logic [127:0] tt, tt_z;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q1[$];
    exp_t q0[$];

    minterm_sweeper #(.SETTLE(S1), .SIG_POLY(16'h1021)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .f_in(f_in),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .busy(busy), .done(done), .ones_count(ones_count), .signature(signature)
    );

    minterm_sweeper #(.SETTLE(S0), .SIG_POLY(16'h1021)) dut0 (
        .clk(clk), .rst(rst), .start(start_z), .pause(1'b0), .f_in(f_in_z),
        .a(a_z), .b(b_z), .c(c_z), .d(d_z), .e(e_z), .f(f_z), .g(g_z),
        .busy(busy_z), .done(done_z), .ones_count(ones_z), .signature(sig_z)
    );

    assign idx    = {a, b, c, d, e, f, g};
    assign idx_z  = {a_z, b_z, c_z, d_z, e_z, f_z, g_z};
    assign f_in   = tt[idx];
    assign f_in_z = tt_z[idx_z];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: count ones and run the CRC over the truth table in index order.
    function automatic exp_t model(input logic [127:0] t, input int settle, input int extra);
        exp_t        r;
        logic [15:0] s;
        int          n;
        s = 16'hFFFF;
        n = 0;
        for (int i = 0; i < 128; i++) begin
            n += int'(t[i]);
            s = {s[14:0], 1'b0} ^ ((s[15] ^ t[i]) ? 16'h1021 : 16'h0000);
        end
        r.ones    = n;
        r.sig     = s;
        r.t_start = 0;
        r.lat     = 1 + 128 * (2 + settle) + extra;
        return r;
    endfunction

    // Truth tables: 0 all ones, 1 f=g, 2 f=a&b, 3 random.
    function automatic logic [127:0] mk_tt(input int mode);
        logic [127:0] t;
        for (int i = 0; i < 128; i++) begin
            case (mode)
                0:       t[i] = 1'b1;
                1:       t[i] = (i % 2) == 1;
                2:       t[i] = (i >= 96);
                default: t[i] = $urandom_range(0, 1) == 1;
            endcase
        end
        return t;
    endfunction

    // Monitor for the SETTLE=1 instance.
    always @(negedge clk) begin : mon1
        exp_t x;
        if (!rst && done) begin
            if (q1.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                x = q1.pop_front();
                check("ones_count", 32'(ones_count), 32'(x.ones));
                check("signature", 32'(signature), 32'(x.sig));
                check("latency", 32'(cyc - x.t_start), 32'(x.lat));
                check("done_busy", 32'(busy), 32'd0);
                check("done_inputs", 32'(idx), 32'd0);
            end
        end
    end

    // Monitor for the SETTLE=0 instance.
    always @(negedge clk) begin : mon0
        exp_t x;
        if (!rst && done_z) begin
            if (q0.size() == 0) begin
                check("spurious_done0", 32'(done_z), 32'd0);
            end else begin
                x = q0.pop_front();
                check("ones_count0", 32'(ones_z), 32'(x.ones));
                check("signature0", 32'(sig_z), 32'(x.sig));
                check("latency0", 32'(cyc - x.t_start), 32'(x.lat));
            end
        end
    end

    task automatic issue(input logic [127:0] t, input int extra, input bit with_pause);
        exp_t x;
        tt        = t;
        x         = model(t, S1, extra);
        x.t_start = cyc;
        q1.push_back(x);
        start = 1'b1;
        pause = with_pause;
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic wait_done(input bit z);
        int n = 0;
        while (n < 3000 && !(z ? done_z : done)) begin
            @(negedge clk);
            n++;
        end
        if (!(z ? done_z : done)) check("done_timeout", 32'(z ? done_z : done), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_index(input logic [6:0] target);
        int n = 0;
        while (n < 3000 && !(busy && idx == target)) begin
            @(negedge clk);
            n++;
        end
        if (!(busy && idx == target)) check("index_timeout", 32'(idx), 32'(target));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [127:0] t;
        exp_t         m;
        logic [7:0]   h_ones;
        logic [15:0]  h_sig;
        exp_t         x;

        rst = 1'b1; start = 1'b0; pause = 1'b0; start_z = 1'b0;
        tt = '0; tt_z = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_inputs", 32'(idx), 32'd0);
        check("rst_ones", 32'(ones_count), 32'd0);
        check("rst_sig", 32'(signature), 32'hFFFF);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fixed tables, with a hold check after the all-ones sweep.
        t = mk_tt(0);
        m = model(t, S1, 0);
        issue(t, 0, 1'b0);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(1'b0);
        repeat (3) @(negedge clk);
        check("hold_ones", 32'(ones_count), 32'(m.ones));
        check("hold_sig", 32'(signature), 32'(m.sig));
        check("idle_inputs", 32'(idx), 32'd0);
        for (int mode = 1; mode <= 3; mode++) begin
            issue(mk_tt(mode), 0, 1'b0);
            wait_done(1'b0);
            @(negedge clk);
        end

        // Pause for 10 cycles in SETTLE at index 40.
        issue(mk_tt(3), 10, 1'b0);
        wait_index(7'd40);
        @(negedge clk);
        h_ones = ones_count;
        h_sig  = signature;
        pause  = 1'b1;
        repeat (10) @(negedge clk);
        check("pause_index", 32'(idx), 32'd40);
        check("pause_ones", 32'(ones_count), 32'(h_ones));
        check("pause_sig", 32'(signature), 32'(h_sig));
        check("pause_busy", 32'(busy), 32'd1);
        pause = 1'b0;
        wait_done(1'b0);

        // Start re-pulsed mid-sweep is ignored.
        issue(mk_tt(3), 0, 1'b0);
        wait_index(7'd20);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_ignored", 32'(idx), 32'd20);
        wait_done(1'b0);

        // Start together with pause in IDLE begins the sweep.
        issue(mk_tt(3), 0, 1'b1);
        check("start_pause_busy", 32'(busy), 32'd1);
        wait_done(1'b0);

        // Asynchronous reset mid-sweep at index 77.
        issue(mk_tt(3), 0, 1'b0);
        wait_index(7'd77);
        #2;
        rst = 1'b1;
        #1;
        q1.delete();
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_inputs", 32'(idx), 32'd0);
        check("arst_ones", 32'(ones_count), 32'd0);
        check("arst_sig", 32'(signature), 32'hFFFF);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("no_resume", 32'(busy), 32'd0);
        issue(mk_tt(3), 0, 1'b0);
        wait_done(1'b0);

        // SETTLE=0 instance: 257-cycle sweeps.
        for (int k = 0; k < 2; k++) begin
            tt_z      = mk_tt(k == 0 ? 1 : 3);
            x         = model(tt_z, S0, 0);
            x.t_start = cyc;
            q0.push_back(x);
            start_z = 1'b1;
            @(negedge clk);
            start_z = 1'b0;
            wait_done(1'b1);
        end

        repeat (3) @(negedge clk);
        check("pending_q1", 32'(q1.size()), 32'd0);
        check("pending_q0", 32'(q0.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/minterm_sweeper.md
MINTERM_SWEEPER -- requirements
Module: minterm_sweeper

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, giving the wait cycles (0..15) between driving inputs and sampling f_in.
REQ-002 The block SHALL have parameter SIG_POLY, default 16'h1021, giving the signature feedback polynomial.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request for a full 128-point sweep.
REQ-006 The block SHALL have port pause, input, 1 bit: freezes the sweep while high.
REQ-007 The block SHALL have port f_in, input, 1 bit: the output of the downstream 7-input boolean function under test.
REQ-008 The block SHALL have ports a, b, c, d, e, f, g, output, 1 bit each: the function inputs; a is the MSB of the index and g is the LSB.
REQ-009 The block SHALL have port busy, output, 1 bit: high from sweep acceptance until done.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking sweep completion.
REQ-011 The block SHALL have port ones_count, output, 8 bits: number of sampled 1s (range 0..128).
REQ-012 The block SHALL have port signature, output, 16 bits: serial CRC of the sampled outputs.

Function
REQ-013 The FSM SHALL have the states IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-014 In IDLE with start=1, the block SHALL, at the next edge, clear index to 0, set ones_count to 0, set signature to 16'hFFFF, and enter DRIVE.
REQ-015 {a..g} SHALL equal index in every state except IDLE and DONE, where they SHALL be 0.
REQ-016 DRIVE SHALL last 1 cycle, then go to SETTLE if SETTLE>0, else to SAMPLE.
REQ-017 SETTLE SHALL last exactly SETTLE cycles, counted by a 4-bit wait counter.
REQ-018 SAMPLE SHALL last 1 cycle and SHALL register f_in.
- ones_count += f_in.
- signature <= {signature[14:0],1'b0} ^ ((signature[15]^f_in) ? SIG_POLY : 0).
REQ-019 After SAMPLE, if index==127 the block SHALL enter DONE; otherwise it SHALL increment index and enter DRIVE.
REQ-020 The index SHALL never wrap: 127 is terminal.
REQ-021 ones_count SHALL be 8 bits wide so that the value 128 is representable without overflow.
REQ-022 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-023 busy SHALL be 1 in DRIVE, SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-024 Each index SHALL take 2+SETTLE cycles; with start seen at edge N, done SHALL be high in cycle N+1+128*(2+SETTLE).
REQ-025 start outside IDLE SHALL be ignored (no restart, no effect on results).
REQ-026 While pause=1 in DRIVE, SETTLE or SAMPLE, all state SHALL hold: FSM, index, wait counter, ones_count, signature and outputs.
- SAMPLE SHALL neither accumulate nor advance while paused.
- Releasing pause SHALL resume at the same cycle position.
REQ-027 pause SHALL have no effect in IDLE and DONE.
REQ-028 Simultaneous start and pause in IDLE SHALL start the sweep.
REQ-029 ones_count and signature SHALL hold their final values after DONE until the next accepted start.

Reset
REQ-030 rst=1 SHALL immediately, asynchronously, force the following, including mid-sweep:
- FSM to IDLE;
- index, wait counter and a..g to 0;
- busy and done to 0;
- ones_count to 0 and signature to 16'hFFFF.
REQ-031 After rst deasserts, the block SHALL need a fresh start to begin a sweep; an interrupted sweep SHALL NOT resume.

Structure
REQ-032 The FSM state encoding, the value 16'hFFFF (SIG_INIT) and the value 127 (LAST_INDEX) SHALL be defined in the shared package minterm_pkg.
REQ-033 The signature update SHALL be the sub-module sig_crc16, with inputs clk, rst, clear, en and bit and output sig[15:0].
REQ-034 All other logic (FSM, index, wait counter, ones counter) SHALL be in minterm_sweeper.

Verification
REQ-035 f_in tied 1, SETTLE=1, start pulse -> done 385 cycles after start, ones_count=128, signature equals the bench CRC model.
REQ-036 f_in driven from g (index LSB) -> ones_count=64; f_in = a&b -> ones_count=32; signature equals the model in both cases.
REQ-037 Pause held 10 cycles at index 40 (SETTLE state) -> done delayed exactly 10 cycles, results identical to the unpaused run.
REQ-038 rst pulsed at index 77 -> same-cycle busy=0, a..g=0, ones_count=0, signature=16'hFFFF; a new start then completes a full, correct sweep.
REQ-039 start re-pulsed while busy, plus start+pause together in IDLE -> no restart in the first case, sweep begins in the second; SETTLE=0 run completes in 257 cycles.
